// File: rtl/count_sequencer.sv
// count_sequencer
//   Control FSM driving a WIDTH-bit up/down counter with a prescaler. One
//   start request runs the counter from its start value to a target value.
//   The run can be paused, aborted, or reset at any point.
//
//   Ports
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous active-high reset
//     start  in   1      begin a run; sampled only in IDLE
//     pause  in   1      level; freezes the run while high
//     abort  in   1      cancels the run; no done pulse
//     dir    in   1      0 = count up 0->limit, 1 = count down limit->0 (captured at start)
//     limit  in   WIDTH  terminal/initial value (captured at start)
//     count  out  WIDTH  current count (registered)
//     busy   out  1      high in RUN or HOLD
//     paused out  1      high in HOLD
//     done   out  1      one-cycle pulse on terminal count (registered)
//
//   Build option: define COUNT_SEQ_AUTORELOAD_EN to select auto-reload.
//   In that mode the run repeats from the start value after each terminal
//   count, and only abort or rst leaves RUN/HOLD.
module count_sequencer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);
  localparam int            PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] target, step;
  logic             tick;

  assign target = dir_q ? '0 : lim_q;
  assign step   = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
  assign tick   = (ps_q == PS_LAST);

`ifdef COUNT_SEQ_AUTORELOAD_EN
  logic [WIDTH-1:0] start_val;
  assign start_val = dir_q ? lim_q : '0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    ps_d    = ps_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dir_d   = dir;
          lim_d   = limit;
          count_d = dir ? limit : '0;
          ps_d    = '0;
          // limit == 0 means the start value is already the target.
          if (limit == '0) begin
            done_d = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
            state_d = RUN;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = HOLD;
        end else if (tick) begin
          ps_d = '0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
          // Sitting on the target: this tick restarts the sequence.
          if (count_q == target) begin
            count_d = start_val;
            done_d  = (start_val == target);
          end else begin
            count_d = step;
            done_d  = (step == target);
          end
`else
          count_d = step;
          if (step == target) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end else begin
          ps_d = ps_q + PW'(1);
        end
`ifdef COUNT_SEQ_AUTORELOAD_EN
        // A zero-length run is terminal on every cycle.
        if (!abort && lim_q == '0) done_d = 1'b1;
`endif
      end
      HOLD: begin
        // Resuming only changes state; counting picks up on the next cycle.
        if (abort)       state_d = IDLE;
        else if (!pause) state_d = RUN;
`ifdef COUNT_SEQ_AUTORELOAD_EN
        if (!abort && lim_q == '0) done_d = 1'b1;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
      ps_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      ps_q    <= ps_d;
      done_q  <= done_d;
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == RUN) || (state_q == HOLD);
  assign paused = (state_q == HOLD);
  assign done   = done_q;
endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, pause, abort, dir;
  logic [7:0] limit;
  logic [7:0] c1, c4;
  logic       b1, p1, d1, b4, p4, d4;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .dir(dir),
    .limit(limit), .count(c1), .busy(b1), .paused(p1), .done(d1));

  count_sequencer #(.WIDTH(8), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .dir(dir),
    .limit(limit), .count(c4), .busy(b4), .paused(p4), .done(d4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; dir = 1'b0; limit = 8'd0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({c1, b1, p1, d1} !== 11'd0) begin
      n_bad++; $display("FAIL reset_p1: got c=%0d b=%0d p=%0d d=%0d expected all 0", c1, b1, p1, d1);
    end
    n_cmp++;
    if ({c4, b4, p4, d4} !== 11'd0) begin
      n_bad++; $display("FAIL reset_p4: got c=%0d b=%0d p=%0d d=%0d expected all 0", c4, b4, p4, d4);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    limit = 8'd5; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) step();
      n_cmp++;
      if (c1 !== 8'(i) || b1 !== (i < 5) || d1 !== (i == 5)) begin
        n_bad++;
        $display("FAIL up_seq[%0d]: got c=%0d b=%0d d=%0d expected c=%0d b=%0d d=%0d",
                 i, c1, b1, d1, i, (i < 5), (i == 5));
      end
    end
    step();
    n_cmp++;
    if (c1 !== 8'd5 || b1 !== 1'b0 || d1 !== 1'b0) begin
      n_bad++; $display("FAIL up_after: got c=%0d b=%0d d=%0d expected c=5 b=0 d=0", c1, b1, d1);
    end
  endtask

  task automatic test_count_down();
    int pulses = 0;
    do_reset();
    limit = 8'd3; dir = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (c1 !== 8'd3) begin
      n_bad++; $display("FAIL down_init: got c=%0d expected 3", c1);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i <= 3) begin
        n_cmp++;
        if (c1 !== 8'(3 - i)) begin
          n_bad++; $display("FAIL down_seq[%0d]: got c=%0d expected %0d", i, c1, 3 - i);
        end
      end
      if (d1 === 1'b1) begin
        pulses++;
        n_cmp++;
        if (c1 !== 8'd0 || i != 3) begin
          n_bad++; $display("FAIL down_done_at: got c=%0d cycle=%0d expected c=0 cycle=3", c1, i);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++; $display("FAIL down_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_prescale();
    do_reset();
    limit = 8'd2; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (c4 !== 8'(k / 4) || d4 !== (k == 8)) begin
        n_bad++;
        $display("FAIL presc[%0d]: got c=%0d d=%0d expected c=%0d d=%0d", k, c4, d4, k / 4, (k == 8));
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    limit = 8'd5; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();           // count = 2
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (p1 !== 1'b1 || c1 !== 8'd2 || b1 !== 1'b1) begin
        n_bad++; $display("FAIL pause_hold[%0d]: got p=%0d c=%0d b=%0d expected p=1 c=2 b=1", i, p1, c1, b1);
      end
    end
    pause = 1'b0;
    step();                   // back to RUN, no step this cycle
    n_cmp++;
    if (p1 !== 1'b0 || c1 !== 8'd2) begin
      n_bad++; $display("FAIL pause_resume: got p=%0d c=%0d expected p=0 c=2", p1, c1);
    end
    step();
    n_cmp++;
    if (c1 !== 8'd3) begin
      n_bad++; $display("FAIL pause_next: got c=%0d expected 3", c1);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    do_reset();
    limit = 8'd6; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();   // count = 4
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (c1 !== 8'd4 || b1 !== 1'b0 || d1 !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: got c=%0d b=%0d d=%0d expected c=4 b=0 d=0", c1, b1, d1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (d1 === 1'b1 || b1 === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen);
    end
    // start and abort together in IDLE: nothing captured
    limit = 8'd9; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (b1 !== 1'b0 || c1 !== 8'd4) begin
      n_bad++; $display("FAIL start_abort: got b=%0d c=%0d expected b=0 c=4", b1, c1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    limit = 8'd3; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();                   // count = 1
    limit = 8'd9; dir = 1'b1; start = 1'b1;
    step();                   // start ignored while busy
    start = 1'b0;
    n_cmp++;
    if (c1 !== 8'd2 || b1 !== 1'b1) begin
      n_bad++; $display("FAIL start_busy: got c=%0d b=%0d expected c=2 b=1", c1, b1);
    end
    step();
    n_cmp++;
    if (c1 !== 8'd3 || d1 !== 1'b1) begin
      n_bad++; $display("FAIL start_busy_done: got c=%0d d=%0d expected c=3 d=1", c1, d1);
    end
  endtask

  task automatic test_limit_zero();
    do_reset();
    limit = 8'd0; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (d1 !== 1'b1 || c1 !== 8'd0 || b1 !== 1'b0) begin
      n_bad++; $display("FAIL lim0: got d=%0d c=%0d b=%0d expected d=1 c=0 b=0", d1, c1, b1);
    end
    step();
    n_cmp++;
    if (d1 !== 1'b0) begin
      n_bad++; $display("FAIL lim0_pulse: got d=%0d expected 0", d1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    limit = 8'd9; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();   // count = 3, mid-cycle now
    rst = 1'b1;
    #1;
    n_cmp++;
    if (c1 !== 8'd0 || b1 !== 1'b0 || d1 !== 1'b0) begin
      n_bad++; $display("FAIL async_rst: got c=%0d b=%0d d=%0d expected all 0", c1, b1, d1);
    end
    rst = 1'b0;
  endtask

`ifdef COUNT_SEQ_AUTORELOAD_EN
  task automatic test_autoreload();
    int pulses = 0;
    do_reset();
    limit = 8'd2; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      n_cmp++;
      if (c1 !== 8'(i % 3) || d1 !== (i % 3 == 2) || b1 !== 1'b1) begin
        n_bad++;
        $display("FAIL autoreload[%0d]: got c=%0d d=%0d b=%0d expected c=%0d d=%0d b=1",
                 i, c1, d1, b1, i % 3, (i % 3 == 2));
      end
      if (d1 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 3) begin
      n_bad++; $display("FAIL autoreload_pulses: got %0d expected 3", pulses);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (b1 !== 1'b0) begin
      n_bad++; $display("FAIL autoreload_abort: got b=%0d expected 0", b1);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef COUNT_SEQ_AUTORELOAD_EN
    test_autoreload();
    test_pause();
    test_async_reset();
`else
    test_count_up();
    test_count_down();
    test_prescale();
    test_pause();
    test_abort();
    test_back_to_back();
    test_limit_zero();
    test_async_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
